// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush-to-NOP.
// Optional stall/bubble performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_skid #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic [1:0]        occupancy
);

    // state | meaning
    // EMPTY | nothing held, outputs are NOP
    // FULL  | main register holds the presented entry
    // SKID  | main presented, skid holds the next entry, upstream held off
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t              r_state;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;

    state_t              w_state_nxt;
    logic [CTRL_W-1:0]   w_main_ctrl_nxt;
    logic [DATA_W-1:0]   w_main_data_nxt;
    logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
    logic [DATA_W-1:0]   w_skid_data_nxt;
    logic                w_acc;
    logic                w_rel;

    // in_ready comes straight from the state register, never from out_ready.
    assign in_ready  = (r_state != SKID);
    assign out_valid = (r_state != EMPTY);
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;
    assign w_acc     = in_valid & in_ready;
    assign w_rel     = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (r_state)
            FULL:    occupancy = 2'd1;
            SKID:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;
        if (flush) begin
            w_state_nxt     = EMPTY;
            w_main_ctrl_nxt = '0;
            w_main_data_nxt = '0;
            w_skid_ctrl_nxt = '0;
            w_skid_data_nxt = '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt     = FULL;
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                    end
                end
                FULL: begin
                    if (w_acc && w_rel) begin
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                    end else if (w_acc) begin
                        w_state_nxt     = SKID;
                        w_skid_ctrl_nxt = in_ctrl;
                        w_skid_data_nxt = in_data;
                    end else if (w_rel) begin
                        w_state_nxt     = EMPTY;
                        w_main_ctrl_nxt = '0;
                        w_main_data_nxt = '0;
                    end
                end
                SKID: begin
                    if (w_rel) begin
                        w_state_nxt     = FULL;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_main_data_nxt = r_skid_data;
                        w_skid_ctrl_nxt = '0;
                        w_skid_data_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt     = EMPTY;
                    w_main_ctrl_nxt = '0;
                    w_main_data_nxt = '0;
                    w_skid_ctrl_nxt = '0;
                    w_skid_data_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (!out_valid && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
